// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Segment patterns are active-low and ordered {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Entry N holds the pattern for hex digit N (entry 15 is the leftmost field).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

endpackage

// File: rtl/seg_scan_ctrl_hex_to_seg.sv
// Combinational hex-digit to active-low seven-segment pattern lookup.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode display scanner: prescaled tick, BLANK/DRIVE slots per digit,
// per-frame shadow capture of the display data, and fully registered pin drive.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIV_BITS = 16,
    parameter int ON_TICKS = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  digit_en,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam logic [3:0] SLOT_LAST = 4'(ON_TICKS - 1);

    logic [DIV_BITS-1:0] presc_q, presc_d;
    state_t              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [3:0]          slot_q, slot_d;
    logic [15:0]         shadow_value_q, shadow_value_d;
    logic [3:0]          shadow_en_q, shadow_en_d;
    logic [3:0]          shadow_dp_q, shadow_dp_d;
    logic [3:0]          an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic                frame_done_q, frame_done_d;

    logic                tick;
    logic [3:0]          digit_sel;
    logic [6:0]          seg_dec;

    assign tick = (presc_q == '1);

    // Slot sequencing; shadows only reload when digit 0 starts, so a frame never tears.
    always_comb begin
        presc_d        = presc_q + 1'b1;
        state_d        = state_q;
        idx_d          = idx_q;
        slot_d         = slot_q;
        shadow_value_d = shadow_value_q;
        shadow_en_d    = shadow_en_q;
        shadow_dp_d    = shadow_dp_q;
        frame_done_d   = 1'b0;

        case (state_q)
            BLANK: begin
                if (tick) begin
                    state_d = DRIVE;
                    slot_d  = 4'd0;
                    if (idx_q == 2'd0) begin
                        shadow_value_d = value;
                        shadow_en_d    = digit_en;
                        shadow_dp_d    = dp_in;
                    end
                end
            end
            DRIVE: begin
                if (tick) begin
                    if (slot_q == SLOT_LAST) begin
                        state_d      = BLANK;
                        idx_d        = idx_q + 2'd1;
                        frame_done_d = (idx_q == 2'd3);
                    end else begin
                        slot_d = slot_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = BLANK;
            end
        endcase
    end

    // Pins are computed from next-state values so they change on the transition edge.
    assign digit_sel = shadow_value_d[{idx_d, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .digit (digit_sel),
        .seg   (seg_dec)
    );

    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (state_d == DRIVE && shadow_en_d[idx_d]) begin
            an_d  = ~(4'b0001 << idx_d);
            seg_d = seg_dec;
            dp_d  = ~shadow_dp_d[idx_d];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q        <= '0;
            state_q        <= BLANK;
            idx_q          <= 2'd0;
            slot_q         <= 4'd0;
            shadow_value_q <= 16'h0000;
            shadow_en_q    <= 4'h0;
            shadow_dp_q    <= 4'h0;
            an_q           <= AN_OFF;
            seg_q          <= SEG_OFF;
            dp_q           <= 1'b1;
            frame_done_q   <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            state_q        <= state_d;
            idx_q          <= idx_d;
            slot_q         <= slot_d;
            shadow_value_q <= shadow_value_d;
            shadow_en_q    <= shadow_en_d;
            shadow_dp_q    <= shadow_dp_d;
            an_q           <= an_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexing controller for a 4-digit, common-anode seven-segment display. An internal prescaler generates a refresh tick. On each tick a small state machine advances, driving one digit at a time with a blanking slot between digits to prevent ghosting. Display data is captured once per frame so a digit cannot show a mix of old and new values. The block sits between the datapath's 16-bit display value and the board's anode/segment pins.

Parameters:
DIV_BITS, 16, prescaler width; tick period = 2^DIV_BITS clk cycles
ON_TICKS, 3, ticks each digit is driven (range 1..15)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
value  in  16  four hex digits; digit i = value[4i+3:4i]
digit_en  in  4  per-digit enable; 0 blanks that digit
dp_in  in  4  per-digit decimal point, 1 = lit
an  out  4  anode drive, active-low, an[i] selects digit i
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low
frame_done  out  1  one-cycle pulse at the end of each full 4-digit frame

Behaviour:
- Reset (asynchronous, held while reset=1):
  - prescaler=0, state=BLANK, idx=0, slot counter=0.
  - Shadow registers (value, digit_en, dp_in) = 0.
  - Outputs: an=4'hF, seg=7'h7F, dp=1, frame_done=0.
- Prescaler:
  - Free-running DIV_BITS-bit up-counter, wraps at 2^DIV_BITS-1.
  - tick=1 in the cycle the count equals all-ones.
  - First tick after reset release occurs on cycle 2^DIV_BITS-1.
- State machine (advances only on tick):
  - BLANK lasts 1 tick. On tick -> DRIVE, slot counter=0. If idx==0, the shadows load value/digit_en/dp_in on this same edge.
  - DRIVE lasts ON_TICKS ticks. On each tick, slot counter increments.
  - When the slot counter reaches ON_TICKS-1 and tick=1: -> BLANK, idx=(idx+1) mod 4.
  - If idx was 3 on that transition, frame_done=1 for exactly that one cycle.
- Outputs (registered, updated on the same edge as the state transition; no combinational path from inputs to pins):
  - BLANK: an=4'hF, seg=7'h7F, dp=1.
  - DRIVE, shadow_en[idx]=1: an=~(1<<idx), seg=decode(shadow_value digit idx), dp=~shadow_dp[idx].
  - DRIVE, shadow_en[idx]=0: an=4'hF, seg=7'h7F, dp=1. Slot timing is unchanged, so brightness stays uniform.
- Frame length = 4*(1+ON_TICKS) ticks.
- Input changes mid-frame have no visible effect until the next idx==0 BLANK->DRIVE edge.
- At most one an bit is low in any cycle; an is never low during BLANK.
- Reset asserted mid-DRIVE forces the reset values immediately (asynchronously).

Decomposition:
- Shared package seg_pkg:
  - 16-entry segment pattern constant (0-F, active-low, {g..a}).
  - SEG_OFF = 7'h7F, AN_OFF = 4'hF.
  - State enum {BLANK, DRIVE}.
- One natural sub-module: hex_to_seg (combinational 4-bit -> 7-bit lookup using the package table), instantiated once on the shadow-digit mux output.

Test Plan:
(All scenarios use DIV_BITS=2, ON_TICKS=2: tick every 4 cycles, frame = 12 ticks = 48 cycles.)
1. Reset: assert reset mid-DRIVE -> an=F, seg=7F, dp=1, frame_done=0 within the same cycle; after release, first tick at cycle 3.
2. value=16'h1234, digit_en=F, dp_in=0 -> successive DRIVE slots show:
   - an=E, seg=19 ('4')
   - an=D, seg=30 ('3')
   - an=B, seg=24 ('2')
   - an=7, seg=79 ('1')
   Each slot is 8 cycles, separated by 4-cycle an=F blanks.
3. Anti-tearing: change value to 16'hABCD while digit 2 is driven -> digits 2 and 3 still show '2' and '1'. Next frame shows:
   - digit 0: seg=21 ('d')
   - digit 1: seg=46 ('C')
   - digit 2: seg=03 ('b')
   - digit 3: seg=08 ('A')
4. digit_en=4'b0101, dp_in=4'b0001 -> digit 0 lit with dp=0; digits 1 and 3 keep an=F for their full 8-cycle slots; frame period stays 48 cycles.
5. frame_done is high for exactly 1 cycle every 48 cycles, coincident with the digit-3 DRIVE->BLANK edge. A checker asserts at most one an bit is low in every cycle.
6. Exhaustive decode: sweep digits 0-F through digit 0 -> seg matches the seg_pkg table for all 16 values.
